tile_ram_arbiter: RTL and testbench
===================================

TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 13, tile RAM address width
- DATA_WIDTH, 3, tile code width
- DEPTH, 4800, tile entries (80x60)
- CLEAR_VALUE, 0, tile code written by the clear engine
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, single clock
- i_rst, in, 1, synchronous active-high reset
- i_vid_req, in, 1, video read request
- i_vid_addr, in, ADDR_WIDTH, video read address
- o_vid_valid, out, 1, video read data valid pulse
- o_vid_data, out, DATA_WIDTH, video read data
- i_gm_req, in, 1, game access request; held until o_gm_ack
- i_gm_write, in, 1, 1 = write, 0 = read
- i_gm_addr, in, ADDR_WIDTH, game address
- i_gm_data, in, DATA_WIDTH, game write data
- o_gm_ack, out, 1, game access accepted this cycle
- o_gm_valid, out, 1, game read data valid pulse
- o_gm_data, out, DATA_WIDTH, game read data, held until the next game read
- o_ram_addr, out, ADDR_WIDTH, to RAM address
- o_ram_write, out, 1, to RAM write strobe
- o_ram_data, out, DATA_WIDTH, to RAM write data
- i_ram_data, in, DATA_WIDTH, from RAM registered read data (1-cycle latency; not updated on write cycles)
- i_clr_start, in, 1, start clear sweep (TILE_ARB_CLEAR_EN only)
- o_clr_busy, out, 1, clear sweep in progress (TILE_ARB_CLEAR_EN only)

Function
REQ-003 SHALL drive the RAM port combinationally each cycle from exactly one owner, priority: video > clear > game > idle.
REQ-004 SHALL drive the idle RAM port as o_ram_write=0, with o_ram_addr and o_ram_data held at their previous values.
REQ-005 SHALL grant video in every cycle i_vid_req=1, with no handshake; video never stalls.
REQ-006 SHALL assert o_gm_ack only in a cycle with i_gm_req=1, i_vid_req=0 and no clear active; the access is performed that cycle.
REQ-007 SHALL accept at most one game access per o_gm_ack pulse; the requester may keep i_gm_req high for back-to-back accesses.
REQ-008 SHALL give read latency 2 for both video and game reads:
- access in cycle N; RAM registers at edge N+1
- arbiter captures i_ram_data at edge N+2
- o_*_valid high for exactly one cycle (N+2)
REQ-009 SHALL track read ownership with a 2-stage tag pipeline (owner, read flag) so that an interleaved video/game stream routes each result to the correct requester.
REQ-010 SHALL never assert o_*_valid for write accesses.
REQ-011 SHALL hold o_vid_data and o_gm_data between valid pulses.
REQ-012 SHALL use write-through-free semantics: a game read to an address written in the previous cycle returns the new value, since the RAM write completes at edge N+1.

Reset
REQ-013 SHALL, on i_rst=1 at a clock edge, clear the tag pipeline and force o_vid_valid=0, o_gm_valid=0, o_gm_ack=0, o_vid_data=0, o_gm_data=0, o_ram_write=0, o_ram_addr=0, o_ram_data=0, o_clr_busy=0, clear counter=0, FSM=IDLE.
REQ-014 SHALL drop reads in flight at reset; no valid pulse follows the reset.

Configuration
REQ-015 SHALL compile the clear engine only when macro TILE_ARB_CLEAR_EN is defined.
REQ-016 SHALL implement the clear engine, when TILE_ARB_CLEAR_EN is defined, as FSM IDLE/CLEAR:
- i_clr_start in IDLE -> CLEAR on the next edge; o_clr_busy=1
- each CLEAR cycle without video writes CLEAR_VALUE to the counter address, then counter+1
- video cycles stall the counter
- o_gm_ack=0 throughout CLEAR
- the write to DEPTH-1 -> IDLE; counter=0; o_clr_busy=0 on the following cycle
- i_clr_start during CLEAR is ignored
- reset during CLEAR aborts the sweep
REQ-017 SHALL, without TILE_ARB_CLEAR_EN, omit i_clr_start, o_clr_busy and the CLEAR state, leaving game arbitration unaffected.

Verification
REQ-018 Video-only read: i_vid_req=1 at addr 2020 (RAM preloaded 4) -> o_vid_valid in cycle N+2 with o_vid_data=4.
REQ-019 Contention: i_vid_req and i_gm_req both high for 3 cycles, then video drops -> o_gm_ack=0 for 3 cycles, then 1; video pulses 3 valids.
REQ-020 Game write then read: write 5 at addr 1765, then read 1765 next cycle -> o_gm_valid 2 cycles later with o_gm_data=5; no o_gm_valid on the write.
REQ-021 Interleave: video reads A/C alternated with game reads B/D -> every result is routed to the correct requester in order.
REQ-022 Reset mid-read: i_rst asserted in cycle N+1 -> no valid pulse in N+2; all outputs are 0.
REQ-023 (TILE_ARB_CLEAR_EN) Clear with 10 interleaved video cycles -> o_clr_busy for 4810 cycles; all 4800 entries read back CLEAR_VALUE; i_gm_req is not acked until busy drops.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// Single-port tile RAM arbiter: video > clear > game, 2-cycle read latency with tag routing.
// Optional clear engine compiled in with `define TILE_ARB_CLEAR_EN.
module tile_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned DATA_WIDTH  = 3,
    parameter int unsigned DEPTH       = 4800,
    parameter int unsigned CLEAR_VALUE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vid_req,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic                  o_vid_valid,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    input  logic                  i_gm_req,
    input  logic                  i_gm_write,
    input  logic [ADDR_WIDTH-1:0] i_gm_addr,
    input  logic [DATA_WIDTH-1:0] i_gm_data,
    output logic                  o_gm_ack,
    output logic                  o_gm_valid,
    output logic [DATA_WIDTH-1:0] o_gm_data,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_write,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data
`ifdef TILE_ARB_CLEAR_EN
    ,
    input  logic                  i_clr_start,
    output logic                  o_clr_busy
`endif
);

    if (64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH does not fit in ADDR_WIDTH");
    end
    if (64'(CLEAR_VALUE) >= (64'd1 << DATA_WIDTH)) begin : g_clear_chk
        $error("CLEAR_VALUE does not fit in DATA_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_c;
    logic                  vid_own_c;
    logic                  tag_rd_q;
    logic                  tag_vid_q;

`ifdef TILE_ARB_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] CLR_DATA  = DATA_WIDTH'(CLEAR_VALUE);

    typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            o_clr_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_clr_busy <= (state_d == S_CLEAR);
        end
    end

    // Sweep advances only on cycles video leaves the RAM port free
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (i_clr_start) begin
                state_d = S_CLEAR;
            end
        end else if (!i_vid_req) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
        end
    end
`endif

    // RAM port owner select; idle keeps the last address/data on the bus
    always_comb begin
        o_ram_addr  = addr_q;
        o_ram_data  = data_q;
        o_ram_write = 1'b0;
        o_gm_ack    = 1'b0;
        rd_c        = 1'b0;
        vid_own_c   = 1'b0;
        if (!i_rst) begin
            if (i_vid_req) begin
                o_ram_addr = i_vid_addr;
                rd_c       = 1'b1;
                vid_own_c  = 1'b1;
            end
`ifdef TILE_ARB_CLEAR_EN
            else if (state_q == S_CLEAR) begin
                o_ram_addr  = cnt_q;
                o_ram_data  = CLR_DATA;
                o_ram_write = 1'b1;
            end
`endif
            else if (i_gm_req) begin
                o_gm_ack    = 1'b1;
                o_ram_addr  = i_gm_addr;
                o_ram_write = i_gm_write;
                rd_c        = !i_gm_write;
                if (i_gm_write) begin
                    o_ram_data = i_gm_data;
                end
            end
        end
    end

    // Tag stage 1 follows the RAM's own register; stage 2 is the valid/data capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            tag_rd_q    <= 1'b0;
            tag_vid_q   <= 1'b0;
            o_vid_valid <= 1'b0;
            o_gm_valid  <= 1'b0;
            o_vid_data  <= '0;
            o_gm_data   <= '0;
        end else begin
            addr_q      <= o_ram_addr;
            data_q      <= o_ram_data;
            tag_rd_q    <= rd_c;
            tag_vid_q   <= vid_own_c;
            o_vid_valid <= tag_rd_q && tag_vid_q;
            o_gm_valid  <= tag_rd_q && !tag_vid_q;
            if (tag_rd_q && tag_vid_q) begin
                o_vid_data <= i_ram_data;
            end
            if (tag_rd_q && !tag_vid_q) begin
                o_gm_data <= i_ram_data;
            end
        end
    end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Randomized + directed bench for tile_ram_arbiter against a cycle-stamped scoreboard model.
module tb_tile_ram_arbiter;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 3;
    localparam int unsigned DEPTH = 4800;
    localparam int unsigned CLRV  = 0;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_vid_req = 1'b0;
    logic [AW-1:0] i_vid_addr = '0;
    logic          o_vid_valid;
    logic [DW-1:0] o_vid_data;
    logic          i_gm_req = 1'b0;
    logic          i_gm_write = 1'b0;
    logic [AW-1:0] i_gm_addr = '0;
    logic [DW-1:0] i_gm_data = '0;
    logic          o_gm_ack;
    logic          o_gm_valid;
    logic [DW-1:0] o_gm_data;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_write;
    logic [DW-1:0] o_ram_data;
    logic [DW-1:0] i_ram_data;
`ifdef TILE_ARB_CLEAR_EN
    logic          i_clr_start = 1'b0;
    logic          o_clr_busy;
`endif

    tile_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CLEAR_VALUE(CLRV)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
        .o_vid_valid(o_vid_valid), .o_vid_data(o_vid_data),
        .i_gm_req(i_gm_req), .i_gm_write(i_gm_write), .i_gm_addr(i_gm_addr),
        .i_gm_data(i_gm_data), .o_gm_ack(o_gm_ack), .o_gm_valid(o_gm_valid),
        .o_gm_data(o_gm_data), .o_ram_addr(o_ram_addr), .o_ram_write(o_ram_write),
        .o_ram_data(o_ram_data), .i_ram_data(i_ram_data)
`ifdef TILE_ARB_CLEAR_EN
        , .i_clr_start(i_clr_start), .o_clr_busy(o_clr_busy)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Environment RAM: registered read, read data not updated on write cycles
    logic [DW-1:0] ram [DEPTH];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge i_clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (o_ram_write) ram[o_ram_addr] <= o_ram_data;
        else i_ram_data <= (32'(o_ram_addr) < DEPTH) ? ram[o_ram_addr] : '0;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic          exp_vv [4];
    logic [DW-1:0] exp_vd [4];
    logic          exp_gv [4];
    logic [DW-1:0] exp_gd [4];
    logic [DW-1:0] hold_vd, hold_gd;
    logic [AW-1:0] prev_addr;
    logic          clr_m;
    int            clr_cnt_m;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_mis = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            exp_vv[i] = 1'b0; exp_gv[i] = 1'b0; exp_vd[i] = '0; exp_gd[i] = '0;
        end
        hold_vd = '0; hold_gd = '0; prev_addr = '0; clr_m = 1'b0; clr_cnt_m = 0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_vid_req = 1'b0; i_gm_req = 1'b0; i_gm_write = 1'b0;
`ifdef TILE_ARB_CLEAR_EN
        i_clr_start = 1'b0;
`endif
        @(negedge i_clk);
        chk("rst_ack_c", 16'(o_gm_ack), 16'(0));
        chk("rst_ram_wr_c", 16'(o_ram_write), 16'(0));
        @(posedge i_clk); #1; cyc++;
        chk("rst_vid_valid", 16'(o_vid_valid), 16'(0));
        chk("rst_gm_valid", 16'(o_gm_valid), 16'(0));
        chk("rst_vid_data", 16'(o_vid_data), 16'(0));
        chk("rst_gm_data", 16'(o_gm_data), 16'(0));
        chk("rst_ram_addr", 16'(o_ram_addr), 16'(0));
        chk("rst_ram_data", 16'(o_ram_data), 16'(0));
        chk("rst_ram_wr", 16'(o_ram_write), 16'(0));
        chk("rst_gm_ack", 16'(o_gm_ack), 16'(0));
`ifdef TILE_ARB_CLEAR_EN
        chk("rst_clr_busy", 16'(o_clr_busy), 16'(0));
`endif
        model_clear();
        i_rst = 1'b0;
    endtask

    // One clock of stimulus; model predicts port ownership now and read results two cycles on
    task automatic do_cycle(input logic vr, input logic [AW-1:0] va, input logic gr,
                            input logic gw, input logic [AW-1:0] ga, input logic [DW-1:0] gd,
                            input logic cs);
        logic ack_m;
        logic clr_nx;
        int   s;
        i_vid_req = vr; i_vid_addr = va; i_gm_req = gr; i_gm_write = gw;
        i_gm_addr = ga; i_gm_data = gd;
`ifdef TILE_ARB_CLEAR_EN
        i_clr_start = cs;
`endif
        ack_m  = gr && !vr && !clr_m;
        clr_nx = clr_m;
        @(negedge i_clk);
        chk("gm_ack", 16'(o_gm_ack), 16'(ack_m));
        s = (cyc + 2) % 4;
        exp_vv[s] = vr;
        exp_vd[s] = vr ? ref_mem[va] : '0;
        exp_gv[s] = ack_m && !gw;
        exp_gd[s] = ref_mem[ga];
        if (vr) begin
            chk("ram_addr_vid", 16'(o_ram_addr), 16'(va));
            chk("ram_wr_vid", 16'(o_ram_write), 16'(0));
            prev_addr = va;
        end else if (clr_m) begin
            chk("ram_addr_clr", 16'(o_ram_addr), 16'(clr_cnt_m));
            chk("ram_wr_clr", 16'(o_ram_write), 16'(1));
            chk("ram_data_clr", 16'(o_ram_data), 16'(CLRV));
            ref_mem[clr_cnt_m] = DW'(CLRV);
            prev_addr = AW'(clr_cnt_m);
            clr_cnt_m++;
            if (clr_cnt_m == int'(DEPTH)) begin
                clr_nx = 1'b0; clr_cnt_m = 0;
            end
        end else if (ack_m) begin
            chk("ram_addr_gm", 16'(o_ram_addr), 16'(ga));
            chk("ram_wr_gm", 16'(o_ram_write), 16'(gw));
            if (gw) begin
                chk("ram_data_gm", 16'(o_ram_data), 16'(gd));
                ref_mem[ga] = gd;
            end
            prev_addr = ga;
        end else begin
            chk("ram_wr_idle", 16'(o_ram_write), 16'(0));
            chk("ram_addr_idle", 16'(o_ram_addr), 16'(prev_addr));
        end
        if (cs && !clr_m) begin
            clr_nx = 1'b1; clr_cnt_m = 0;
        end
`ifndef TILE_ARB_CLEAR_EN
        clr_nx = 1'b0;
`endif
        @(posedge i_clk); #1; cyc++;
        clr_m = clr_nx;
        s = cyc % 4;
        chk("vid_valid", 16'(o_vid_valid), 16'(exp_vv[s]));
        if (exp_vv[s]) hold_vd = exp_vd[s];
        chk("vid_data", 16'(o_vid_data), 16'(hold_vd));
        chk("gm_valid", 16'(o_gm_valid), 16'(exp_gv[s]));
        if (exp_gv[s]) hold_gd = exp_gd[s];
        chk("gm_data", 16'(o_gm_data), 16'(hold_gd));
`ifdef TILE_ARB_CLEAR_EN
        chk("clr_busy", 16'(o_clr_busy), 16'(clr_m));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] last_ga;
        int            busy_cnt;
        int            vcnt;
        int            k;
        model_clear();
        // Preload RAM and model with the same random contents while in reset
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = DW'($urandom);
            if (i == 2020) ref_mem[i] = 3'd4;
            if (i == 1765) ref_mem[i] = 3'd2;
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = ref_mem[i];
            @(posedge i_clk); #1;
        end
        pre_we = 1'b0;
        do_reset();

        // Video-only read of a preloaded entry
        do_cycle(1'b1, 13'd2020, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(2);
        chk("vid_2020", 16'(o_vid_data), 16'(4));

        // Contention: video holds the port for three cycles, then game is acked
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, AW'(100 + i), 1'b1, 1'b0, 13'd200, '0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 13'd200, '0, 1'b0);
        idle(2);

        // Game write then read-back the following cycle
        do_cycle(1'b0, '0, 1'b1, 1'b1, 13'd1765, 3'd5, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 13'd1765, '0, 1'b0);
        idle(2);
        chk("gm_1765", 16'(o_gm_data), 16'(5));

        // Interleaved video/game reads
        do_cycle(1'b1, 13'd10, 1'b0, 1'b0, '0, '0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 13'd20, '0, 1'b0);
        do_cycle(1'b1, 13'd30, 1'b0, 1'b0, '0, '0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 13'd40, '0, 1'b0);
        idle(2);

        // Reset while a video read is in flight
        do_cycle(1'b1, 13'd2020, 1'b0, 1'b0, '0, '0, 1'b0);
        do_reset();
        idle(2);

        // Random mixed traffic, sometimes reusing the last game address
        last_ga = 13'd5;
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ga;
            ga = ($urandom_range(0, 3) == 0) ? last_ga : AW'($urandom_range(0, DEPTH - 1));
            last_ga = ga;
            do_cycle($urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ga,
                     DW'($urandom), 1'b0);
        end
        idle(2);

`ifdef TILE_ARB_CLEAR_EN
        // Clear sweep with ten video cycles interleaved and game requesting throughout
        do_cycle(1'b0, '0, 1'b1, 1'b0, 13'd7, '0, 1'b1);
        busy_cnt = o_clr_busy ? 1 : 0;
        vcnt = 0;
        k = 0;
        while (clr_m && k < 6000) begin
            logic vr;
            vr = (k % 300 == 5) && (vcnt < 10);
            if (vr) vcnt++;
            do_cycle(vr, AW'($urandom_range(0, DEPTH - 1)), 1'b1, 1'b0,
                     AW'($urandom_range(0, DEPTH - 1)), '0, 1'b1);
            if (o_clr_busy) busy_cnt++;
            k++;
        end
        chk("clr_busy_len", 16'(busy_cnt), 16'(4810));
        for (int i = 0; i < int'(DEPTH); i++)
            do_cycle(1'b0, '0, 1'b1, 1'b0, AW'(i), '0, 1'b0);
        idle(2);
`else
        busy_cnt = 0; vcnt = 0; k = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
